// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the sequential radix-2 Booth multiplier controller:
//   - state_e        : controller state encoding
//   - PAIR_ADD/SUB   : Booth pair codes {Q[0], q(-1)} that require an adder op
//   - DEF_*          : default widths and the latency of the 16-bit pipelined
//                      ripple-carry adder this block drives
//   - pair_needs_add : true when a Booth pair calls for an add or subtract
// -----------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXAM  = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

    localparam int DEF_N       = 8;
    localparam int DEF_W       = 16;
    localparam int DEF_ADD_LAT = 16;

    function automatic logic pair_needs_add(input logic [1:0] pair);
        return (pair == PAIR_ADD) || (pair == PAIR_SUB);
    endfunction

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// booth_seq_ctrl_if
// Bundles the request/result handshake and the external adder bus.
//   start, mcand, mplier      : request side (into the controller)
//   busy, done, product       : result side (out of the controller)
//   add_a, add_b, add_cin     : adder operands (out of the controller)
//   add_s, add_cout           : adder result (into the controller)
// Modports: master = the Booth controller, slave = requester plus adder.
// -----------------------------------------------------------------------------
interface booth_seq_ctrl_if #(
    parameter int N = 8,
    parameter int W = 16
);
    logic             start;
    logic [N-1:0]     mcand;
    logic [N-1:0]     mplier;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic             add_cin;
    logic [W-1:0]     add_s;
    logic             add_cout;

    modport master (
        input  start, mcand, mplier, add_s, add_cout,
        output busy, done, product, add_a, add_b, add_cin
    );

    modport slave (
        output start, mcand, mplier, add_s, add_cout,
        input  busy, done, product, add_a, add_b, add_cin
    );
endinterface

// File: rtl/booth_lat_timer.sv
// -----------------------------------------------------------------------------
// booth_lat_timer
// Counts out the external adder latency for one add/sub.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   i_load   : pulse on the edge entering WAIT; arms the timer with ADD_LAT
//   o_expire : high during the single cycle whose closing edge captures add_s
// Loaded with ADD_LAT, it counts down to zero, so WAIT lasts ADD_LAT+1 cycles.
// -----------------------------------------------------------------------------
module booth_lat_timer
    import booth_pkg::*;
#(
    parameter int ADD_LAT = DEF_ADD_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_expire
);
    localparam int CW = $clog2(ADD_LAT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_armed;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else if (i_load) begin
            r_cnt   <= CW'(ADD_LAT);
            r_armed <= 1'b1;
        end else if (r_armed) begin
            if (r_cnt == '0) r_armed <= 1'b0;
            else             r_cnt   <= r_cnt - 1'b1;
        end
    end

    // Armed flag keeps the idle zero count from looking like an expiry.
    assign o_expire = r_armed && (r_cnt == '0);
endmodule

// File: rtl/booth_seq_ctrl.sv
// -----------------------------------------------------------------------------
// booth_seq_ctrl
// Sequential radix-2 Booth multiplier (signed N x N -> 2N) that performs every
// add/subtract through an external pipelined adder of latency ADD_LAT.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, overrides everything
//   bus  : booth_seq_ctrl_if.master
//          start/mcand/mplier in, busy/done/product out,
//          add_a/add_b/add_cin out (registered), add_s/add_cout in
// Booth state: r_acc (N+1 bits so M = -2^(N-1) is exact), r_qr, r_q1.
// -----------------------------------------------------------------------------
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int W       = DEF_W,
    parameter int ADD_LAT = DEF_ADD_LAT
) (
    input  logic                clk,
    input  logic                rst,
    booth_seq_ctrl_if.master    bus
);
    localparam int            CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_e               r_state, w_state_nxt;
    logic signed [N:0]    r_acc;
    logic [N-1:0]         r_qr;
    logic                 r_q1;
    logic signed [N-1:0]  r_mr;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*N-1:0]       r_product;
    logic [W-1:0]         r_add_a, r_add_b;
    logic                 r_add_cin;

    logic [1:0]           w_pair;
    logic                 w_timer_load, w_expire;
    logic signed [N:0]    w_sh_acc;
    logic [N-1:0]         w_sh_qr;
    logic                 w_sh_q1;
    logic                 w_unused;

    assign w_pair = {r_qr[0], r_q1};

    // Arithmetic right shift of {ACC, Qr, q1}: ACC sign bit is replicated.
    assign {w_sh_acc, w_sh_qr, w_sh_q1} = {r_acc[N], r_acc, r_qr};

    // Carry-out and adder bits above the ACC width carry no information.
    assign w_unused = ^{bus.add_cout, bus.add_s[W-1:N+1]};

    booth_lat_timer #(.ADD_LAT(ADD_LAT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_timer_load),
        .o_expire (w_expire)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_load = 1'b0;
        unique case (r_state)
            IDLE:  if (bus.start) w_state_nxt = EXAM;
            EXAM: begin
                if (pair_needs_add(w_pair)) begin
                    w_state_nxt  = WAIT;
                    w_timer_load = 1'b1;
                end else begin
                    w_state_nxt  = SHIFT;
                end
            end
            WAIT:  if (w_expire) w_state_nxt = SHIFT;
            SHIFT: w_state_nxt = (r_cnt == LAST) ? DONE : EXAM;
            DONE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_qr      <= '0;
            r_q1      <= 1'b0;
            r_mr      <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_add_cin <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mr  <= bus.mcand;
                        r_qr  <= bus.mplier;
                        r_acc <= '0;
                        r_q1  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                EXAM: begin
                    // Subtract is ACC + ~M + 1; size casts sign-extend to W.
                    if (w_pair == PAIR_ADD) begin
                        r_add_a   <= W'(r_acc);
                        r_add_b   <= W'(r_mr);
                        r_add_cin <= 1'b0;
                    end else if (w_pair == PAIR_SUB) begin
                        r_add_a   <= W'(r_acc);
                        r_add_b   <= ~W'(r_mr);
                        r_add_cin <= 1'b1;
                    end
                end
                WAIT: begin
                    if (w_expire) r_acc <= bus.add_s[N:0];
                end
                SHIFT: begin
                    r_acc <= w_sh_acc;
                    r_qr  <= w_sh_qr;
                    r_q1  <= w_sh_q1;
                    if (r_cnt == LAST) r_product <= {w_sh_acc[N-1:0], w_sh_qr};
                    else               r_cnt     <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = (r_state == DONE);
    assign bus.product = r_product;
    assign bus.add_a   = r_add_a;
    assign bus.add_b   = r_add_b;
    assign bus.add_cin = r_add_cin;
endmodule

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
- Sequential radix-2 Booth multiplier control/datapath stage; signed N x N -> 2N product.
- Sits directly upstream of the team's 16-bit pipelined ripple-carry adder. It drives the adder's A/B/Cin and consumes its S after the adder's fixed pipeline latency.
- Owns the Booth state (accumulator, multiplier shift register, q(-1) bit), the iteration count and the latency wait. Adds and subtracts are done only through the external adder.

Parameters:
- N, 8, operand width (signed two's complement); requires N+1 <= W.
- W, 16, external adder width.
- ADD_LAT, 16, adder latency in clock edges from first operand-sampling edge to S/Cout valid.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- mcand  in  N  multiplicand M, signed; captured on accept.
- mplier  in  N  multiplier Q, signed; captured on accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when product is valid.
- product  out  2N  signed result; held until the next accept.
- add_a  out  W  adder operand A, registered.
- add_b  out  W  adder operand B, registered.
- add_cin  out  1  adder carry-in, registered.
- add_s  in  W  adder sum.
- add_cout  in  1  adder carry-out; ignored.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, product=0, add_a=0, add_b=0, add_cin=0; internal registers cleared. rst overrides all other events.
- Reset mid-operation: abort to IDLE. Data still in the adder pipeline is never consumed, because every add waits its full latency.
- Registers: ACC (N+1 bits, signed), Qr (N bits), q1 (1 bit), Mr (N bits), cnt (0..N-1).
- IDLE: if start=1, accept on that edge: Mr=mcand, Qr=mplier, ACC=0, q1=0, cnt=0, go to EXAM.
  - start while busy is ignored, not queued.
- EXAM, one cycle, decodes {Qr[0],q1}:
  - 01: add_a = sext_W(ACC), add_b = sext_W(Mr), add_cin=0; go to WAIT.
  - 10: add_a = sext_W(ACC), add_b = ~sext_W(Mr), add_cin=1 (ACC-M); go to WAIT.
  - 00 or 11: go to SHIFT; add_* hold their previous values.
- WAIT, exactly ADD_LAT+1 cycles:
  - add_* stay stable throughout.
  - Let E0 be the edge leaving EXAM. At edge E0+ADD_LAT+1, ACC = add_s[N:0] (mod 2^(N+1)); go to SHIFT.
- SHIFT, one cycle:
  - Arithmetic right shift of {ACC,Qr,q1}; ACC[N] is replicated.
  - If cnt==N-1, go to DONE; otherwise cnt=cnt+1 and go to EXAM.
- DONE, one cycle: done=1, product={ACC,Qr}[2N-1:0]; go to IDLE.
- Width rule: the N+1-bit ACC makes M = -2^(N-1) exact. Overflow is impossible, since |product| <= 2^(2N-2).
- Timing: an iteration takes 2 cycles without an add and ADD_LAT+3 cycles with an add. done rises at accept edge + 2N + k*(ADD_LAT+1) edges, where k is the number of add/sub ops (16 + 17k for the defaults).
- busy falls in the cycle after DONE. A start in that IDLE cycle is accepted, giving back-to-back operation.

Decomposition:
- Shared package booth_pkg holds:
  - state encoding constants IDLE/EXAM/WAIT/SHIFT/DONE;
  - Booth pair codes (PAIR_ADD=01, PAIR_SUB=10);
  - the default ADD_LAT=16 matching the 16-bit pipelined adder.
- One sub-module: booth_lat_timer. It is loaded with ADD_LAT on entry to WAIT and asserts expire on the capture cycle.
- Everything else stays in booth_seq_ctrl.

Test Plan:
- Tie the controller to the real 16-bit pipelined adder. Check every result against a signed reference model and check done timing against the formula.
- mcand=3, mplier=0 -> no adds; done at accept+16 edges; product=0x0000.
- mcand=3, mplier=1 -> one sub then one add (k=2); done at accept+50 edges; product=0x0003.
- mcand=-128, mplier=-128 -> product=0x4000 (16384); mcand=127, mplier=-128 -> product=0xC080 (-16256); mcand=-1, mplier=-1 -> product=0x0001.
- Assert start again during WAIT of a 5 x 7 op -> ignored; product=0x0023; exactly one done pulse.
- Assert rst during WAIT of a 25 x -3 op, then start 6 x 9 -> after rst all outputs 0; second result 0x0036 (no stale adder data); done timing per formula.
- Back-to-back: start held high through DONE for 12 x 12 then 100 x -100 -> second accept in the cycle after DONE; products 0x0090 then 0xD8F0.
